// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings: decoder jump/branch codes, fetch FSM states
// and the default reset PC.
package mips_pkg;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_JAL  = 2'b10;
  localparam logic [1:0] JUMP_JR   = 2'b11;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } if_state_t;

endpackage

// File: rtl/if_next_pc.sv
// Combinational redirect calculator: decides whether the instruction on the
// fetch output redirects the PC and where to.
module if_next_pc
  import mips_pkg::*;
(
  input  logic [1:0]  jump,
  input  logic [1:0]  branch,
  input  logic        zero,
  input  logic [25:0] index,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] jr_target,
  output logic        taken,
  output logic [31:0] target
);

  logic        br_taken;
  logic [31:0] branch_target;

  assign branch_target = pc_plus4 + {{14{index[15]}}, index[15:0], 2'b00};

  // Jump encodings outrank any simultaneous branch encoding.
  always_comb begin
    br_taken = ((branch == BR_BEQ) && zero) || ((branch == BR_BNE) && !zero);
    taken    = (jump != JUMP_NONE) || br_taken;
    target   = pc_plus4;
    case (jump)
      JUMP_J, JUMP_JAL: target = {pc_plus4[31:28], index, 2'b00};
      JUMP_JR:          target = jr_target;
      default:          if (br_taken) target = branch_target;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, one-outstanding imem handshake FSM
// and next-PC redirect. Optional IF_MISALIGN_CHECK_EN adds a sticky misalign flag.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_AW  = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  output logic               inst_valid,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic [31:0]        pc_plus4,
  input  logic [1:0]         jump,
  input  logic [1:0]         branch,
  input  logic               zero,
  input  logic [31:0]        jr_target
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic               fetch_misalign
`endif
);

  if_state_t          state, state_next;
  logic [IMEM_AW-1:0] pc;
  logic [31:0]        inst_q, inst_pc_q;
  logic               valid_q, discard;
  logic               load, drop, consume, redirect, taken;
  logic [31:0]        target, target_aligned;

  // Registered outputs are forced to their reset values during the reset cycle.
  assign imem_req       = (state == S_REQ) && !reset;
  assign imem_addr      = reset ? RESET_PC : pc;
  assign inst_valid     = valid_q && !reset;
  assign inst           = reset ? '0 : inst_q;
  assign inst_pc        = reset ? '0 : inst_pc_q;
  assign pc_plus4       = inst_pc + 32'd4;
  assign target_aligned = {target[31:2], 2'b00};

  if_next_pc u_next_pc (
    .jump      (jump),
    .branch    (branch),
    .zero      (zero),
    .index     (inst_q[25:0]),
    .pc_plus4  (pc_plus4),
    .jr_target (jr_target),
    .taken     (taken),
    .target    (target)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    consume    = inst_valid && !stall;
    redirect   = consume && taken;
    case (state)
      S_REQ:  if (imem_ready) state_next = S_WAIT;
      S_WAIT: if (imem_rvalid) begin
                drop       = discard;
                load       = !discard;
                state_next = discard ? S_REQ : S_HOLD;
              end
      S_HOLD: if (consume) state_next = S_REQ;
      default: state_next = S_REQ;
    endcase
    if (redirect) state_next = S_REQ;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      discard   <= 1'b0;
    end else begin
      if (load) begin
        inst_q    <= imem_rdata;
        inst_pc_q <= pc;
        valid_q   <= 1'b1;
        pc        <= pc + 32'd4;
      end
      if (drop)    discard <= 1'b0;
      if (consume) valid_q <= 1'b0;
      if (redirect) begin
        pc <= target_aligned;
        // A redirect racing an outstanding read must drop the stale data.
        if (state == S_WAIT) discard <= 1'b1;
      end
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)                                   fetch_misalign <= 1'b0;
    else if (redirect && (target[1:0] != 2'b00)) fetch_misalign <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: hand sequences, redirect vector table
// and randomized decode/memory timing against a transaction-level PC model.
module tb_if_fetch_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic [1:0]  jump;
  logic [1:0]  branch;
  logic        zero;
  logic [31:0] jr_target;
`ifdef IF_MISALIGN_CHECK_EN
  logic        fetch_misalign;
  logic        exp_mis;
`endif

  if_fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .pc_plus4    (pc_plus4),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .jr_target   (jr_target)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_fetch;
  int          ready_delay, rv_lat;
  int          acc_count = 0;
  logic [31:0] last_acc_addr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [1:0]  j;
    logic [1:0]  b;
    logic        z;
    logic [31:0] jr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[31:2] ^ 30'h2AAA_5555, 2'b10};
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input logic [1:0] j, input logic [1:0] b,
                                           input logic z, input logic [31:0] jr);
    logic [31:0] p4;
    int          off;
    p4  = pc + 32'd4;
    off = int'($signed(ins[15:0])) * 4;
    if (j == 2'd1 || j == 2'd2) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (j == 2'd3) return jr & 32'hFFFF_FFFC;
    if ((b == 2'd1 && z) || (b == 2'd2 && !z)) return p4 + 32'(off);
    return p4;
  endfunction

  // Memory responder: one outstanding read, configurable accept gap and read latency.
  logic        pending, prev_wait, s_acc, s_rv, s_req;
  logic [31:0] paddr, prev_addr, s_addr;
  int          cnt, idle;
  initial begin
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    pending = 1'b0; prev_wait = 1'b0; prev_addr = '0; paddr = '0; cnt = 0; idle = 0;
    forever begin
      @(negedge clk); #3;
      s_req  = imem_req;
      s_acc  = imem_req && imem_ready;
      s_rv   = imem_rvalid;
      s_addr = imem_addr;
      if (prev_wait && !reset) begin
        check("req_hold", imem_req, 1);
        check("addr_hold", imem_addr, prev_addr);
      end
      prev_wait = imem_req && !imem_ready && !reset;
      prev_addr = imem_addr;
      if (s_acc) begin
        check("fetch_addr", s_addr, exp_fetch);
        last_acc_addr = s_addr;
      end
      @(posedge clk); #1;
      if (s_rv) pending = 1'b0;
      else if (pending && cnt > 0) cnt--;
      if (s_acc) begin
        pending = 1'b1; paddr = s_addr; cnt = rv_lat; idle = 0; acc_count++;
      end else if (s_req) idle++;
      else idle = 0;
      imem_ready  = !pending && (idle >= ready_delay);
      imem_rvalid = pending && (cnt == 0);
      imem_rdata  = imem_rvalid ? mem_word(paddr) : 32'h0BAD_0BAD;
    end
  end

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!inst_valid && n < budget) begin @(negedge clk); n++; end
    if (!inst_valid) check("present_timeout", inst_valid, 1);
    else begin
      check("inst_pc", inst_pc, exp_fetch);
      check("inst", inst, mem_word(exp_fetch));
      check("pc_plus4", pc_plus4, exp_fetch + 32'd4);
    end
  endtask

  task automatic wait_accept(input logic [31:0] exp, input int budget);
    int start = acc_count;
    int n = 0;
    while (acc_count == start && n < budget) begin @(negedge clk); n++; end
    if (acc_count == start) check("accept_timeout", 32'(acc_count), 32'(start + 1));
    else check("redirect_addr", last_acc_addr, exp);
  endtask

  task automatic stall_cycles(input int k);
    logic [31:0] i0, p0;
    i0 = inst; p0 = inst_pc;
    stall = 1'b1;
    for (int c = 0; c < k; c++) begin
      jump = 2'($urandom_range(0, 3)); branch = 2'($urandom_range(0, 3));
      zero = 1'($urandom_range(0, 1)); jr_target = $urandom;
      @(negedge clk);
      check("stall_valid", inst_valid, 1);
      check("stall_inst", inst, i0);
      check("stall_pc", inst_pc, p0);
      check("stall_req", imem_req, 0);
    end
  endtask

  task automatic consume(input logic [1:0] j, input logic [1:0] b, input logic z, input logic [31:0] jr);
    stall = 1'b0; jump = j; branch = b; zero = z; jr_target = jr;
`ifdef IF_MISALIGN_CHECK_EN
    if (j == 2'd3 && jr[1:0] != 2'b00) exp_mis = 1'b1;
`endif
    exp_fetch = ref_next(exp_fetch, mem_word(exp_fetch), j, b, z, jr);
    @(negedge clk);
    check("consumed", inst_valid, 0);
    jump = '0; branch = '0; zero = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    check("misalign", fetch_misalign, exp_mis);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  rj, rb;
    logic        rz;
    logic [31:0] rjr;
    reset = 1'b1; stall = 1'b0; jump = '0; branch = '0; zero = 1'b0; jr_target = '0;
    ready_delay = 0; rv_lat = 0; exp_fetch = 32'h0;
`ifdef IF_MISALIGN_CHECK_EN
    exp_mis = 1'b0;
`endif
    mem[32'h0] = 32'h2000_0001;
    vecs[0]  = '{32'h0000_0100, 32'h1000_FFFF, 2'd0, 2'd1, 1'b1, 32'h0, 32'h0000_0100};
    vecs[1]  = '{32'h0000_0100, 32'h1000_FFFF, 2'd0, 2'd1, 1'b0, 32'h0, 32'h0000_0104};
    vecs[2]  = '{32'h0000_0100, 32'h1000_FFFF, 2'd0, 2'd2, 1'b0, 32'h0, 32'h0000_0100};
    vecs[3]  = '{32'h0000_0100, 32'h1000_FFFF, 2'd0, 2'd2, 1'b1, 32'h0, 32'h0000_0104};
    vecs[4]  = '{32'h1000_0000, 32'h0800_0040, 2'd1, 2'd0, 1'b0, 32'h0, 32'h1000_0100};
    vecs[5]  = '{32'h0000_0300, 32'h0000_0000, 2'd3, 2'd0, 1'b0, 32'h400, 32'h0000_0400};
    vecs[6]  = '{32'hF000_0000, 32'h0FFF_FFFF, 2'd2, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFFC};
    vecs[7]  = '{32'h1000_0000, 32'h0800_0040, 2'd1, 2'd1, 1'b1, 32'h0, 32'h1000_0100};
    vecs[8]  = '{32'h0000_0100, 32'h1000_FFFF, 2'd0, 2'd3, 1'b1, 32'h0, 32'h0000_0104};
    vecs[9]  = '{32'hFFFF_FFFC, 32'h0000_0000, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0000_0000};
    vecs[10] = '{32'h0000_0200, 32'h1000_0010, 2'd0, 2'd1, 1'b1, 32'h0, 32'h0000_0244};
    vecs[11] = '{32'h0000_0010, 32'h1000_FFF0, 2'd0, 2'd1, 1'b1, 32'h0, 32'hFFFF_FFD4};
    vecs[12] = '{32'h0000_0300, 32'h0000_0000, 2'd3, 2'd0, 1'b0, 32'h402, 32'h0000_0400};
    foreach (vecs[i]) mem[vecs[i].pc] = vecs[i].ins;

    // Reset values, then zero-wait first fetch.
    @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("wait_req", imem_req, 0);
    check("wait_valid", inst_valid, 0);
    @(negedge clk);
    check("first_valid", inst_valid, 1);
    wait_valid(1);

    // Stall hold, then slow memory on the next fetch.
    stall_cycles(5);
    ready_delay = 3; rv_lat = 4;
    consume(2'd0, 2'd0, 1'b0, 32'h0);
    wait_accept(32'h4, 20);
    wait_valid(30);
    ready_delay = 0; rv_lat = 6;

    // Reset while a read is outstanding; stale data must be ignored.
    consume(2'd0, 2'd0, 1'b0, 32'h0);
    wait_accept(32'h8, 20);
    rv_lat = 0;
    reset = 1'b1;
    exp_fetch = 32'h0;
`ifdef IF_MISALIGN_CHECK_EN
    exp_mis = 1'b0;
`endif
    @(negedge clk);
    check("midrst_req", imem_req, 0);
    check("midrst_valid", inst_valid, 0);
    reset = 1'b0;
    wait_valid(40);
    check("restart_pc", inst_pc, 32'h0);

    foreach (vecs[i]) begin
      consume(2'd3, 2'd0, 1'b0, vecs[i].pc);
      wait_valid(30);
      check("vec_pc", inst_pc, vecs[i].pc);
      consume(vecs[i].j, vecs[i].b, vecs[i].z, vecs[i].jr);
      wait_accept(vecs[i].exp, 20);
      wait_valid(30);
    end

    for (int n = 0; n < 150; n++) begin
      if (n % 20 == 0) begin
        ready_delay = $urandom_range(0, 3);
        rv_lat      = $urandom_range(0, 3);
      end
      wait_valid(30);
      if (!inst_valid) break;
      if ($urandom_range(0, 2) == 0) stall_cycles($urandom_range(1, 3));
      rj  = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'd0;
      rb  = 2'($urandom_range(0, 3));
      rz  = 1'($urandom_range(0, 1));
      rjr = $urandom;
      if ($urandom_range(0, 3) != 0) rjr[1:0] = 2'b00;
      consume(rj, rb, rz, rjr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
